// File: rtl/seq_serializer_if.sv
// Handshake and serial-output bundle for seq_serializer.
interface seq_serializer_if #(
  parameter int WIDTH = 8
);
  // valid/ready: a word transfers on a rising clk edge where din_valid && din_ready;
  // din_ready never looks at din_valid, and din is ignored on edges without a transfer.
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             bit_en;
  logic             x;
  logic             x_valid;
  logic             last;

  modport master (
    output din, din_valid, bit_en,
    input  din_ready, x, x_valid, last
  );

  modport slave (
    input  din, din_valid, bit_en,
    output din_ready, x, x_valid, last
  );
endinterface

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end for the 101 detectors; LSB first by default,
// MSB first when SEQ_SER_MSB_FIRST_EN is defined.
module seq_serializer #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  seq_serializer_if.slave    bus,
  output logic               dbg_state
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg_next;
  logic             out_bit;
  logic             accept;
  logic             cnt_zero;

`ifdef SEQ_SER_MSB_FIRST_EN
  assign out_bit   = sreg[WIDTH-1];
  assign sreg_next = {sreg[WIDTH-2:0], 1'b0};
`else
  assign out_bit   = sreg[0];
  assign sreg_next = {1'b0, sreg[WIDTH-1:1]};
`endif

  assign cnt_zero      = (cnt == '0);
  // Ready on the final enabled bit as well, so back-to-back words need no gap cycle.
  assign bus.din_ready = rst && ((state == ST_IDLE) ||
                                 ((state == ST_SHIFT) && cnt_zero && bus.bit_en));
  assign accept        = bus.din_valid && bus.din_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sreg  <= bus.din;
            cnt   <= CW'(WIDTH - 1);
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bus.bit_en) begin
            if (!cnt_zero) begin
              sreg <= sreg_next;
              cnt  <= cnt - 1'b1;
            end else if (accept) begin
              sreg <= bus.din;
              cnt  <= CW'(WIDTH - 1);
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.x       = (state == ST_SHIFT) ? out_bit : IDLE_BIT;
  assign bus.x_valid = (state == ST_SHIFT);
  assign bus.last    = (state == ST_SHIFT) && cnt_zero;
  assign dbg_state   = state;
endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: reset, single word, gapless, stall, detector chain.
module tb_seq_serializer;
  localparam int W = 8;

`ifdef SEQ_SER_MSB_FIRST_EN
  localparam logic [W-1:0] WORD_A   = 8'hA0;
  localparam logic [W-1:0] WORD_B   = 8'h50;
  localparam logic [W-1:0] WORD_DET = 8'hA8;
`else
  localparam logic [W-1:0] WORD_A   = 8'h05;
  localparam logic [W-1:0] WORD_B   = 8'h0A;
  localparam logic [W-1:0] WORD_DET = 8'h15;
`endif

  logic clk;
  logic rst;
  logic dbg_state;
  int   checks;
  int   failures;

  seq_serializer_if #(.WIDTH(W)) sif ();

  seq_serializer #(.WIDTH(W), .IDLE_BIT(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (sif),
    .dbg_state (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference 101 Moore detector fed through an input register
  localparam logic [1:0] D_S0 = 2'd0, D_S1 = 2'd1, D_S10 = 2'd2, D_S101 = 2'd3;
  logic [1:0] det_state;
  logic       det_xq;
  logic       det_y;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      det_state <= D_S0;
      det_xq    <= 1'b0;
    end else begin
      det_xq <= sif.x;
      case (det_state)
        D_S0:    det_state <= det_xq ? D_S1   : D_S0;
        D_S1:    det_state <= det_xq ? D_S1   : D_S10;
        D_S10:   det_state <= det_xq ? D_S101 : D_S0;
        default: det_state <= det_xq ? D_S1   : D_S10;
      endcase
    end
  end
  assign det_y = (det_state == D_S101);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    sif.din = '0; sif.din_valid = 1'b0; sif.bit_en = 1'b0;
    #12;
    checks++;
    if (sif.x !== 1'b0 || sif.x_valid !== 1'b0 || sif.last !== 1'b0 || sif.din_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: x=%b x_valid=%b last=%b din_ready=%b, need 0 0 0 0",
               sif.x, sif.x_valid, sif.last, sif.din_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (sif.din_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: din_ready=%b need 1", sif.din_ready);
    end
    tick();
    // mid-word reset: accept 8'hFF, let three bits go out, then reset
    sif.din = 8'hFF; sif.din_valid = 1'b1; sif.bit_en = 1'b1;
    tick();
    sif.din_valid = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (sif.x_valid !== 1'b1 || sif.x !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_word: x=%b x_valid=%b need 1 1", sif.x, sif.x_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (sif.x !== 1'b0 || sif.x_valid !== 1'b0 || sif.last !== 1'b0 || sif.din_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_midword: x=%b x_valid=%b last=%b din_ready=%b, need 0 0 0 0",
               sif.x, sif.x_valid, sif.last, sif.din_ready);
    end
    #6;
    rst = 1'b1;
    #1;
    checks++;
    if (sif.din_ready !== 1'b1 || dbg_state !== 1'b0) begin
      failures++;
      $display("FAIL reset_midword_release: din_ready=%b state=%b need 1 0", sif.din_ready, dbg_state);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (sif.x_valid !== 1'b0 || sif.x !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_leftover cyc%0d: x=%b x_valid=%b need 0 0", i, sif.x, sif.x_valid);
      end
    end
  endtask

  task automatic test_single_word();
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp;
    exp_q = '{1, 0, 1, 0, 0, 0, 0, 0};
    sif.din = WORD_A; sif.din_valid = 1'b1; sif.bit_en = 1'b1;
    #1;
    checks++;
    if (sif.din_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_ready_idle: din_ready=%b need 1", sif.din_ready);
    end
    tick();
    sif.din_valid = 1'b0;
    sif.din = 8'hFF;
    for (int i = 0; i < W; i++) begin
      exp = exp_q.pop_front();
      checks++;
      if (sif.x !== exp[0] || sif.x_valid !== 1'b1 || sif.last !== (i == W - 1)) begin
        failures++;
        $display("FAIL single_bit%0d: x=%b x_valid=%b last=%b need %b 1 %b",
                 i, sif.x, sif.x_valid, sif.last, exp[0], (i == W - 1));
      end
      tick();
    end
    checks++;
    if (sif.x_valid !== 1'b0 || sif.x !== 1'b0 || sif.last !== 1'b0) begin
      failures++;
      $display("FAIL single_after: x=%b x_valid=%b last=%b need 0 0 0", sif.x, sif.x_valid, sif.last);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp;
    exp_q = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0};
    tick();
    sif.din = WORD_A; sif.din_valid = 1'b1; sif.bit_en = 1'b1;
    tick();
    sif.din = WORD_B;
    for (int i = 0; i < 2 * W; i++) begin
      exp = exp_q.pop_front();
      checks++;
      if (sif.x !== exp[0] || sif.x_valid !== 1'b1 ||
          sif.din_ready !== (i == W - 1 || i == 2 * W - 1)) begin
        failures++;
        $display("FAIL b2b_bit%0d: x=%b x_valid=%b din_ready=%b need %b 1 %b",
                 i, sif.x, sif.x_valid, sif.din_ready, exp[0], (i == W - 1 || i == 2 * W - 1));
      end
      tick();
      if (i == W - 1) sif.din_valid = 1'b0;
    end
    checks++;
    if (sif.x_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_after: x_valid=%b need 0", sif.x_valid);
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp;
    logic [13:0]  pat;
    int           idx;
    exp_q = '{1, 0, 1, 0, 0, 0, 0, 0};
    pat   = 14'b10_0111_1011_0100;  // applied LSB first: 0,0,1,0,1,1,0,1,1,1,1,0,0,1
    sif.din = WORD_A; sif.din_valid = 1'b1; sif.bit_en = 1'b1;
    tick();
    sif.din_valid = 1'b0;
    idx = 0;
    exp = exp_q.pop_front();
    for (int c = 0; c < 14; c++) begin
      sif.bit_en = pat[c];
      #1;
      checks++;
      if (sif.x !== exp[0] || sif.x_valid !== 1'b1 || sif.last !== (idx == W - 1) ||
          sif.din_ready !== (idx == W - 1 && pat[c])) begin
        failures++;
        $display("FAIL stall_c%0d: x=%b x_valid=%b last=%b din_ready=%b need %b 1 %b %b",
                 c, sif.x, sif.x_valid, sif.last, sif.din_ready, exp[0],
                 (idx == W - 1), (idx == W - 1 && pat[c]));
      end
      tick();
      if (pat[c]) begin
        idx++;
        if (exp_q.size() != 0) exp = exp_q.pop_front();
      end
    end
    sif.bit_en = 1'b1;
    checks++;
    if (idx != W || sif.x_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_end: bits=%0d x_valid=%b need %0d 0", idx, sif.x_valid, W);
    end
  endtask

  task automatic test_detector_chain();
    for (int i = 0; i < 4; i++) tick();
    sif.din = WORD_DET; sif.din_valid = 1'b1; sif.bit_en = 1'b1;
    tick();
    sif.din_valid = 1'b0;
    for (int j = 0; j <= 10; j++) begin
      checks++;
      if (det_y !== (j == 4 || j == 6)) begin
        failures++;
        $display("FAIL detector_y_k+%0d: y=%b need %b", j, det_y, (j == 4 || j == 6));
      end
      tick();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall();
    test_detector_chain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
